// File: rtl/jtopl_mmr.sv
// jtopl_mmr: CPU write port of the OPL core; decodes address/data bus cycles into register-file update strobes.
// Optional: define JTOPL_STATUS_EN to add the rd_n input and dout status output.
module jtopl_mmr #(
  parameter int HOLD = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       addr,
  input  logic [7:0] din,
  output logic [7:0] data,
  output logic [1:0] sel_group,
  output logic [2:0] sel_sub,
  output logic       up_mult,
  output logic       up_ksl_tl,
  output logic       up_ar_dr,
  output logic       up_sl_rr,
  output logic       up_fnum,
  output logic       up_fbcon,
  output logic [4:0] latch_fnum,
  output logic       busy
`ifdef JTOPL_STATUS_EN
  ,
  input  logic       rd_n,
  output logic [7:0] dout
`endif
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_q;
  logic           bus_act_q;
  logic [7:0]     selreg_q;
  logic [7:0]     data_q;
  logic [1:0]     grp_q;
  logic [2:0]     sub_q;
  logic [5:0]     up_q;
  logic [4:0]     fnum_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;

  logic           wr_ev, addr_ev, data_ev;
  logic           dec_valid, fnum_hit;
  logic [5:0]     dec_up;
  logic [1:0]     dec_grp;
  logic [2:0]     dec_sub;
  logic [3:0]     chan;

  // Falling-edge detect on the combined write strobe: one event per bus cycle
  assign wr_ev   = ~cs_n & ~wr_n & ~bus_act_q;
  assign addr_ev = wr_ev & ~addr;
  assign data_ev = wr_ev & addr;
  assign chan    = selreg_q[3:0];

  always_comb begin
    dec_valid = 1'b0;
    fnum_hit  = 1'b0;
    dec_up    = 6'd0;
    dec_grp   = 2'd0;
    dec_sub   = 3'd0;
    case (selreg_q[7:4])
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
        dec_grp   = selreg_q[4:3];
        dec_sub   = selreg_q[2:0];
        dec_valid = (selreg_q[2:0] <= 3'd5) && (selreg_q[4:3] <= 2'd2);
        dec_up    = 6'b000001 << (selreg_q[7:5] - 3'd1);
      end
      4'hA, 4'hC: begin
        dec_grp   = 2'(chan / 4'd3);
        dec_sub   = 3'(chan % 4'd3);
        dec_valid = (chan <= 4'd8);
        dec_up    = selreg_q[6] ? 6'b100000 : 6'b010000;
      end
      4'hB:    fnum_hit = (chan <= 4'd8);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bus_act_q <= 1'b1;  // a bus already low at release must first go idle
      selreg_q  <= 8'd0;
      data_q    <= 8'd0;
      grp_q     <= 2'd0;
      sub_q     <= 3'd0;
      up_q      <= 6'd0;
      fnum_q    <= 5'd0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      bus_act_q <= ~cs_n & ~wr_n;
      if (addr_ev) selreg_q <= din;
      // block/fnum-high latch is taken even during a hold; the held update keeps its data
      if (data_ev && fnum_hit) fnum_q <= din[4:0];
      case (state_q)
        IDLE: begin
          if (data_ev) begin
            data_q <= din;
            if (dec_valid) begin
              grp_q   <= dec_grp;
              sub_q   <= dec_sub;
              up_q    <= dec_up;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cen) begin
            if (cnt_q == CW'(HOLD - 1)) begin
              up_q    <= 6'd0;
              busy_q  <= 1'b0;
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef JTOPL_STATUS_EN
  always_ff @(posedge clk) begin
    if (rst) dout <= 8'd0;
    else     dout <= (~cs_n & ~rd_n & ~addr) ? {busy_q, 7'd0} : 8'd0;
  end
`endif

  assign data       = data_q;
  assign sel_group  = grp_q;
  assign sel_sub    = sub_q;
  assign up_mult    = up_q[0];
  assign up_ksl_tl  = up_q[1];
  assign up_ar_dr   = up_q[2];
  assign up_sl_rr   = up_q[3];
  assign up_fnum    = up_q[4];
  assign up_fbcon   = up_q[5];
  assign latch_fnum = fnum_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_jtopl_mmr.sv
// Scoreboard bench for jtopl_mmr: stimulus pushes expected updates, a monitor pops them on each strobe rise.
module tb_jtopl_mmr;
  localparam int HOLD = 18;

  logic       clk, rst, cen, cs_n, wr_n, addr;
  logic [7:0] din, data;
  logic [1:0] sel_group;
  logic [2:0] sel_sub;
  logic       up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_fnum, up_fbcon, busy;
  logic [4:0] latch_fnum;
`ifdef JTOPL_STATUS_EN
  logic       rd_n;
  logic [7:0] dout;
`endif

  jtopl_mmr #(.HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .cen(cen), .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .din(din),
    .data(data), .sel_group(sel_group), .sel_sub(sel_sub),
    .up_mult(up_mult), .up_ksl_tl(up_ksl_tl), .up_ar_dr(up_ar_dr), .up_sl_rr(up_sl_rr),
    .up_fnum(up_fnum), .up_fbcon(up_fbcon), .latch_fnum(latch_fnum), .busy(busy)
`ifdef JTOPL_STATUS_EN
    , .rd_n(rd_n), .dout(dout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct { int kind; int grp; int sub; int data; int fnum; } exp_t;
  exp_t exp_q[$];

  // cen changes 2 time units after the edge so the monitor at +1 sees the value just used
  bit rand_cen = 0;
  always @(posedge clk) begin
    #2;
    cen = rand_cen ? 1'($urandom % 2) : 1'b1;
  end

  // Monitor: compare each strobe rise against the scoreboard and measure its length in cen pulses
  logic [5:0] strb;
  assign strb = {up_fbcon, up_fnum, up_sl_rr, up_ar_dr, up_ksl_tl, up_mult};
  logic [5:0] prev_s = 6'd0;
  int   hold_cnt = 0;
  exp_t cur;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev_s   = 6'd0;
      hold_cnt = 0;
    end else begin
      if (prev_s != 0 && cen) hold_cnt++;
      if (strb != 0 && prev_s == 0) begin
        hold_cnt = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", strb, 0);
        end else begin
          cur = exp_q.pop_front();
          check("strobe_sel", strb, 1 << cur.kind);
          check("sel_group", sel_group, cur.grp);
          check("sel_sub", sel_sub, cur.sub);
          check("data", data, cur.data);
          check("fnum_at_update", latch_fnum, cur.fnum);
          check("busy_rise", busy, 1);
        end
        $display("update kind=%0d grp=%0d sub=%0d data=0x%02h fnum=0x%02h", cur.kind, sel_group, sel_sub, data, latch_fnum);
      end
      if (strb == 0 && prev_s != 0) begin
        check("hold_len", hold_cnt, HOLD);
        check("busy_fall", busy, 0);
        check("data_frozen", data, cur.data);
        check("grp_frozen", sel_group, cur.grp);
      end
      prev_s = strb;
    end
  end

  // Reference model state
  int m_selreg, m_data, m_fnum;
  bit m_busy;

  function automatic void decode(input int r, output int kind, output int grp, output int sub, output bit fhit);
    int o, c;
    kind = -1; grp = 0; sub = 0; fhit = 0;
    if (r >= 'h20 && r < 'hA0) begin
      o = r % 32; grp = o / 8; sub = o % 8;
      if (sub <= 5 && grp <= 2) kind = r / 32 - 1;
    end else if (r / 16 == 'hA || r / 16 == 'hC) begin
      c = r % 16;
      if (c <= 8) begin
        kind = (r / 16 == 'hA) ? 4 : 5;
        grp = c / 3; sub = c % 3;
      end
    end else if (r / 16 == 'hB && r % 16 <= 8) begin
      fhit = 1;
    end
  endfunction

  task automatic bus_wr(input logic a, input logic [7:0] d, input int len);
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
    repeat (len) @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic m_addr(input logic [7:0] a);
    bus_wr(1'b0, a, 1);
    m_selreg = a;
    $display("addr write 0x%02h", a);
  endtask

  task automatic m_data_wr(input logic [7:0] d, input int len);
    int kind, grp, sub;
    bit fhit;
    exp_t e;
    decode(m_selreg, kind, grp, sub, fhit);
    if (!m_busy) begin
      m_data = d;
      if (kind >= 0) begin
        e.kind = kind; e.grp = grp; e.sub = sub; e.data = d; e.fnum = m_fnum;
        exp_q.push_back(e);
        m_busy = 1;
      end
    end
    if (fhit) m_fnum = d % 32;
    bus_wr(1'b1, d, len);
    $display("data write 0x%02h to reg 0x%02h: data=0x%02h fnum=0x%02h busy=%0d", d, m_selreg, data, latch_fnum, busy);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_data"}, data, m_data);
    check({tag, "_fnum"}, latch_fnum, m_fnum);
    check({tag, "_busy"}, busy, m_busy);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", busy, 0);
    m_busy = 0;
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"}, data, 0);
    check({tag, "_grp"}, sel_group, 0);
    check({tag, "_sub"}, sel_sub, 0);
    check({tag, "_strb"}, strb, 0);
    check({tag, "_fnum"}, latch_fnum, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

`ifdef JTOPL_STATUS_EN
  task automatic status_rd(input int exp);
    @(negedge clk);
    cs_n = 1'b0; rd_n = 1'b0; addr = 1'b0;
    @(negedge clk);
    check("status_dout", dout, exp);
    cs_n = 1'b1; rd_n = 1'b1;
    $display("status read dout=0x%02h", dout);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cen = 1'b1; cs_n = 1'b1; wr_n = 1'b1; addr = 1'b0; din = 8'd0;
`ifdef JTOPL_STATUS_EN
    rd_n = 1'b1;
`endif
    m_selreg = 0; m_data = 0; m_fnum = 0; m_busy = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_zero("reset");

    // Basic operator update
    m_addr(8'h20); m_data_wr(8'h31, 1); check_state("w20");
`ifdef JTOPL_STATUS_EN
    status_rd(8'h80);
`endif
    wait_idle();
`ifdef JTOPL_STATUS_EN
    status_rd(8'h00);
`endif

    // Last valid operator slot, then an invalid offset
    m_addr(8'h55); m_data_wr(8'h3F, 1); check_state("w55"); wait_idle();
    m_addr(8'h46); m_data_wr(8'h12, 1); check_state("w46");

    // fnum high latch then fnum low update
    m_addr(8'hB4); m_data_wr(8'h2A, 1); check_state("wB4");
    m_addr(8'hA4); m_data_wr(8'h9C, 1); check_state("wA4"); wait_idle();

    // Data write during a hold is dropped; address write is taken
    m_addr(8'hC8); m_data_wr(8'hF3, 1);
    m_data_wr(8'h77, 1); check_state("drop77");
    m_addr(8'h60);
    wait_idle();
    m_data_wr(8'h5A, 1); check_state("w60"); wait_idle();

    // Write landing on the edge where busy falls is dropped (cen tied high)
    m_data_wr(8'h11, 1);
    repeat (17) @(negedge clk);
    check("busy_before_fall", busy, 1);
    cs_n = 1'b0; wr_n = 1'b0; addr = 1'b1; din = 8'hEE;
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
    check("busy_after_hold", busy, 0);
    check("fall_edge_drop", data, 8'h11);
    m_busy = 0;
    m_data_wr(8'h22, 1); check_state("after_fall"); wait_idle();

    // Long write strobe: exactly one event
    m_addr(8'h81); m_data_wr(8'h44, 30); wait_idle();

    // Reset mid-hold, with the bus held low across reset release
    m_addr(8'h35); m_data_wr(8'h66, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1; cs_n = 1'b0; wr_n = 1'b0; addr = 1'b1; din = 8'hA5;
    @(negedge clk);
    check_zero("midhold_reset");
    rst = 1'b0;
    exp_q.delete();
    m_selreg = 0; m_data = 0; m_fnum = 0; m_busy = 0;
    repeat (3) @(negedge clk);
    check("low_at_release", data, 0);
    cs_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    check_zero("post_release");

    // Randomized phase with random cen
    rand_cen = 1;
    for (int i = 0; i < 60; i++) begin
      logic [7:0] r;
      case ($urandom % 5)
        0: r = 8'(8'h20 + $urandom % 8'h80);
        1: r = 8'(8'hA0 + $urandom % 10);
        2: r = 8'(8'hC0 + $urandom % 10);
        3: r = 8'(8'hB0 + $urandom % 10);
        default: r = 8'($urandom);
      endcase
      m_addr(r);
      m_data_wr(8'($urandom), 1 + $urandom % 3);
      check_state("rnd");
      if (m_busy && ($urandom % 2)) begin
        m_addr(8'(8'hB0 + $urandom % 9));
        m_data_wr(8'($urandom), 1);
        check_state("rnd_busy");
      end
      if (m_busy) wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
